// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the multi-channel pulse-density modulator.
package pdm_pkg;

   localparam logic MODE_FIRST  = 1'b0;
   localparam logic MODE_SECOND = 1'b1;

   // Write-address width; never narrower than one bit, even for a single channel.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Clamp a value to the signed range of 'width' bits and report whether it clamped.
   function automatic int sat_s(input int value, input int width, output logic clamped);
      int hi;
      int lo;
      int res;
      hi      = (1 << (width - 1)) - 1;
      lo      = -hi - 1;
      clamped = 1'b0;
      res     = value;
      if (value > hi) begin
         res     = hi;
         clamped = 1'b1;
      end else if (value < lo) begin
         res     = lo;
         clamped = 1'b1;
      end
      return res;
   endfunction

endpackage

// File: rtl/pdm_chan_core.sv
// One modulator channel: first-order accumulator, second-order integrator pair,
// registered density bit and sticky overload flag.
module pdm_chan_core
   import pdm_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] x_i,
   input  logic             mode_i,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             clr_ovl_i,
   output logic             pdm_o,
   output logic             ovl_o
);

   localparam int IW = WIDTH + 3;
   localparam int FS = 1 << WIDTH;

   logic [WIDTH-1:0]     acc_q, acc_d;
   logic signed [IW-1:0] i1_q, i1_d;
   logic signed [IW-1:0] i2_q, i2_d;
   logic                 pdm_q, pdm_d;
   logic                 ovl_q, ovl_d;

   logic [WIDTH:0] sum1;
   int             fb;
   int             i1n;
   int             i2n;
   logic           clamp1;
   logic           clamp2;
   logic           ovl_set;

   // Arithmetic for both orders; second-order feedback is the previous output bit at full scale.
   always_comb begin
      sum1 = {1'b0, x_i} + {1'b0, acc_q};
      fb   = pdm_q ? FS : 0;
      i1n  = sat_s(int'(i1_q) + int'(x_i) - fb, IW, clamp1);
      i2n  = sat_s(int'(i2_q) + i1n - fb, IW, clamp2);
   end

   // Next state: a mode change wipes the loop, disable holds it with the output low.
   always_comb begin
      acc_d   = acc_q;
      i1_d    = i1_q;
      i2_d    = i2_q;
      pdm_d   = 1'b0;
      ovl_set = 1'b0;
      if (clear_i) begin
         acc_d = '0;
         i1_d  = '0;
         i2_d  = '0;
      end else if (enable_i) begin
         if (mode_i == MODE_FIRST) begin
            acc_d = sum1[WIDTH-1:0];
            pdm_d = sum1[WIDTH];
         end else begin
            i1_d    = IW'(i1n);
            i2_d    = IW'(i2n);
            pdm_d   = (i2n > 0);
            ovl_set = clamp1 | clamp2;
         end
      end
      // A clamp in the same cycle as a commit is still reported.
      ovl_d = (ovl_q & ~clr_ovl_i) | ovl_set;
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q <= '0;
         i1_q  <= '0;
         i2_q  <= '0;
         pdm_q <= 1'b0;
         ovl_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         i1_q  <= i1_d;
         i2_q  <= i2_d;
         pdm_q <= pdm_d;
         ovl_q <= ovl_d;
      end
   end

   assign pdm_o = pdm_q;
   assign ovl_o = ovl_q;

endmodule

// File: rtl/pdm_multich_mod.sv
// Multi-channel PDM: double-buffered level registers with a global commit,
// sampled noise-shaping mode, one modulator core per channel.
module pdm_multich_mod
   import pdm_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 8,
   localparam int ADDR_W   = addr_w(CHANNELS)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                enable,
   input  logic                mode,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic                commit,
   output logic [CHANNELS-1:0] pdm_out,
   output logic [CHANNELS-1:0] overload
);

   logic [WIDTH-1:0]    shadow_q [CHANNELS];
   logic [WIDTH-1:0]    shadow_d [CHANNELS];
   logic [WIDTH-1:0]    active_q [CHANNELS];
   logic [WIDTH-1:0]    active_d [CHANNELS];
   logic                mode_q;
   logic                mode_chg;
   logic [CHANNELS-1:0] wr_hit;

   assign mode_chg = (mode != mode_q);

   // Address decode; out-of-range addresses match no channel.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         wr_hit[i] = wr_en && (int'(wr_addr) == i);
      end
   end

   // Shadow update and commit; a write coinciding with commit goes straight through.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         shadow_d[i] = wr_hit[i] ? wr_data : shadow_q[i];
         active_d[i] = active_q[i];
         if (commit) begin
            active_d[i] = wr_hit[i] ? wr_data : shadow_q[i];
         end
      end
   end

   // Level and mode registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         mode_q <= MODE_FIRST;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= shadow_d[i];
            active_q[i] <= active_d[i];
         end
         mode_q <= mode;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      pdm_chan_core #(
         .WIDTH (WIDTH)
      ) u_core (
         .clk       (clk),
         .reset_n   (reset_n),
         .x_i       (active_q[g]),
         .mode_i    (mode_q),
         .enable_i  (enable),
         .clear_i   (mode_chg),
         .clr_ovl_i (commit),
         .pdm_o     (pdm_out[g]),
         .ovl_o     (overload[g])
      );
   end

endmodule

// File: tb/tb_pdm_multich_mod.sv
// Self-checking bench for pdm_multich_mod: cycle model built from the
// behavioural rules plus direct density / timing properties.
module tb_pdm_multich_mod;

   localparam int NCH = 3;
   localparam int W   = 8;
   localparam int FS  = 256;
   localparam int IHI = 1023;
   localparam int ILO = -1024;

   logic           clk;
   logic           reset_n;
   logic           enable;
   logic           mode;
   logic           wr_en;
   logic [1:0]     wr_addr;
   logic [W-1:0]   wr_data;
   logic           commit;
   logic [NCH-1:0] pdm_out;
   logic [NCH-1:0] overload;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state
   int m_sh [NCH];
   int m_act[NCH];
   int m_acc[NCH];
   int m_i1 [NCH];
   int m_i2 [NCH];
   bit m_pdm[NCH];
   bit m_ovl[NCH];
   bit m_mode;

   pdm_multich_mod #(.CHANNELS(NCH), .WIDTH(W)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .enable   (enable),
      .mode     (mode),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .commit   (commit),
      .pdm_out  (pdm_out),
      .overload (overload)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int sat(input int v, output bit hit);
      hit = 0;
      if (v > IHI) begin hit = 1; return IHI; end
      if (v < ILO) begin hit = 1; return ILO; end
      return v;
   endfunction

   function automatic logic [NCH-1:0] exp_pdm();
      logic [NCH-1:0] v;
      for (int c = 0; c < NCH; c++) v[c] = m_pdm[c];
      return v;
   endfunction

   function automatic logic [NCH-1:0] exp_ovl();
      logic [NCH-1:0] v;
      for (int c = 0; c < NCH; c++) v[c] = m_ovl[c];
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_sh[c] = 0; m_act[c] = 0; m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
         m_pdm[c] = 0; m_ovl[c] = 0;
      end
      m_mode = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit set_ovl[NCH];
      int s, a, b, fb;
      bit h1, h2, hit;
      for (int c = 0; c < NCH; c++) set_ovl[c] = 0;
      if (mode != m_mode) begin
         m_mode = mode;
         for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_pdm[c] = 0;
         end
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (!enable) begin
               m_pdm[c] = 0;
            end else if (!m_mode) begin
               s        = m_act[c] + m_acc[c];
               m_pdm[c] = (s >= FS);
               m_acc[c] = s % FS;
            end else begin
               fb       = m_pdm[c] ? FS : 0;
               a        = sat(m_i1[c] + m_act[c] - fb, h1);
               b        = sat(m_i2[c] + a - fb, h2);
               m_i1[c]  = a;
               m_i2[c]  = b;
               m_pdm[c] = (b > 0);
               set_ovl[c] = h1 | h2;
            end
         end
      end
      for (int c = 0; c < NCH; c++) begin
         m_ovl[c] = (commit ? 1'b0 : m_ovl[c]) | set_ovl[c];
         hit = wr_en && (int'(wr_addr) == c);
         if (commit) m_act[c] = hit ? int'(wr_data) : m_sh[c];
         if (hit) m_sh[c] = int'(wr_data);
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_level(input int ch, input int val);
      wr_en   = 1'b1;
      wr_addr = 2'(ch);
      wr_data = 8'(val);
      cyc();
      wr_en   = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      cyc();
      commit = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; mode = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; commit = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (pdm_out !== '0) $display("FAIL reset_pdm got=%b exp=%b", pdm_out, 3'b000);
      else n_pass++;
      n_chk++;
      if (overload !== '0) $display("FAIL reset_ovl got=%b exp=%b", overload, 3'b000);
      else n_pass++;
      #2 reset_n = 1'b1;
      enable = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm() || overload !== exp_ovl())
            $display("FAIL post_reset k=%0d pdm=%b exp=%b ovl=%b exp=%b", k, pdm_out, exp_pdm(), overload, exp_ovl());
         else n_pass++;
      end
   endtask

   task automatic test_first_order();
      int first;
      int ones[NCH];
      enable = 1'b1; mode = 1'b0;
      write_level(0, 64);
      write_level(1, 0);
      write_level(2, 255);
      do_commit();
      first = -1;
      for (int c = 0; c < NCH; c++) ones[c] = 0;
      for (int k = 1; k <= 256; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm() || overload !== exp_ovl())
            $display("FAIL fo_cycle k=%0d pdm=%b exp=%b ovl=%b exp=%b", k, pdm_out, exp_pdm(), overload, exp_ovl());
         else n_pass++;
         for (int c = 0; c < NCH; c++) ones[c] += int'(pdm_out[c]);
         if (pdm_out[0] === 1'b1 && first < 0) first = k;
      end
      n_chk++;
      if (first !== 4) $display("FAIL fo_first_high got=%0d exp=4", first); else n_pass++;
      n_chk++;
      if (ones[0] !== 64) $display("FAIL fo_ones_64 got=%0d exp=64", ones[0]); else n_pass++;
      n_chk++;
      if (ones[1] !== 0) $display("FAIL fo_ones_0 got=%0d exp=0", ones[1]); else n_pass++;
      n_chk++;
      if (ones[2] !== 255) $display("FAIL fo_ones_255 got=%0d exp=255", ones[2]); else n_pass++;
   endtask

   task automatic test_double_buffer();
      int ones[NCH];
      write_level(0, 128);
      write_level(1, 32);
      for (int k = 0; k < 8; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm()) $display("FAIL db_shadow k=%0d got=%b exp=%b", k, pdm_out, exp_pdm());
         else n_pass++;
      end
      do_commit();
      for (int k = 0; k < 8; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm()) $display("FAIL db_commit k=%0d got=%b exp=%b", k, pdm_out, exp_pdm());
         else n_pass++;
      end
      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'd200; commit = 1'b1;
      cyc();
      wr_en = 1'b0; commit = 1'b0;
      for (int c = 0; c < NCH; c++) ones[c] = 0;
      for (int k = 0; k < 256; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm()) $display("FAIL db_wthru k=%0d got=%b exp=%b", k, pdm_out, exp_pdm());
         else n_pass++;
         for (int c = 0; c < NCH; c++) ones[c] += int'(pdm_out[c]);
      end
      n_chk++;
      if (ones[0] !== 128 || ones[1] !== 32 || ones[2] !== 200)
         $display("FAIL db_density got=%0d,%0d,%0d exp=128,32,200", ones[0], ones[1], ones[2]);
      else n_pass++;
   endtask

   task automatic test_second_order();
      int ones0, ones1, run, maxrun;
      write_level(0, 128);
      write_level(1, 0);
      write_level(2, int'($urandom_range(1, 255)));
      do_commit();
      mode = 1'b1;
      cyc();
      n_chk++;
      if (pdm_out !== '0) $display("FAIL so_flip_clear got=%b exp=000", pdm_out); else n_pass++;
      ones0 = 0; ones1 = 0; run = 0; maxrun = 0;
      for (int k = 0; k < 1024; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm() || overload !== exp_ovl())
            $display("FAIL so_cycle k=%0d pdm=%b exp=%b ovl=%b exp=%b", k, pdm_out, exp_pdm(), overload, exp_ovl());
         else n_pass++;
         ones0 += int'(pdm_out[0]);
         ones1 += int'(pdm_out[1]);
         run = pdm_out[0] ? run + 1 : 0;
         if (run > maxrun) maxrun = run;
      end
      n_chk++;
      if (ones0 < 511 || ones0 > 513) $display("FAIL so_density got=%0d exp=512+-1", ones0); else n_pass++;
      n_chk++;
      if (maxrun > 2) $display("FAIL so_maxrun got=%0d exp<=2", maxrun); else n_pass++;
      n_chk++;
      if (ones1 !== 0 || overload[1] !== 1'b0)
         $display("FAIL so_zero ones=%0d ovl=%b exp=0,0", ones1, overload[1]);
      else n_pass++;
   endtask

   task automatic test_mode_toggle();
      int ones0;
      mode = 1'b0;
      cyc();
      n_chk++;
      if (pdm_out !== '0) $display("FAIL mt_flip0 got=%b exp=000", pdm_out); else n_pass++;
      for (int k = 0; k < 20; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm()) $display("FAIL mt_fo k=%0d got=%b exp=%b", k, pdm_out, exp_pdm());
         else n_pass++;
      end
      mode = 1'b1;
      cyc();
      n_chk++;
      if (pdm_out !== '0) $display("FAIL mt_flip1 got=%b exp=000", pdm_out); else n_pass++;
      repeat (64) cyc();
      // Out-of-range address, committed in the same cycle: nothing may change.
      wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'($urandom_range(0, 255)); commit = 1'b1;
      cyc();
      wr_en = 1'b0; commit = 1'b0;
      ones0 = 0;
      for (int k = 0; k < 256; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm() || overload !== exp_ovl())
            $display("FAIL mt_cycle k=%0d pdm=%b exp=%b ovl=%b exp=%b", k, pdm_out, exp_pdm(), overload, exp_ovl());
         else n_pass++;
         ones0 += int'(pdm_out[0]);
      end
      n_chk++;
      if (ones0 < 127 || ones0 > 129) $display("FAIL mt_density got=%0d exp=128+-1", ones0); else n_pass++;
   endtask

   task automatic test_enable_gap();
      int lv[NCH];
      bit seq[NCH][60];
      int acc, s;
      logic [NCH-1:0] expv;
      enable = 1'b0; mode = 1'b0;
      cyc();
      for (int c = 0; c < NCH; c++) begin
         lv[c] = int'($urandom_range(1, 255));
         write_level(c, lv[c]);
      end
      do_commit();
      for (int c = 0; c < NCH; c++) begin
         acc = 0;
         for (int k = 0; k < 60; k++) begin
            s = acc + lv[c];
            seq[c][k] = (s >= FS);
            acc = s % FS;
         end
      end
      enable = 1'b1;
      for (int k = 0; k < 50; k++) begin
         if (k == 20) begin
            enable = 1'b0;
            for (int g = 0; g < 10; g++) begin
               cyc();
               n_chk++;
               if (pdm_out !== '0 || pdm_out !== exp_pdm())
                  $display("FAIL gap_low g=%0d got=%b exp=000", g, pdm_out);
               else n_pass++;
            end
            enable = 1'b1;
         end
         cyc();
         for (int c = 0; c < NCH; c++) expv[c] = seq[c][k];
         n_chk++;
         if (pdm_out !== expv) $display("FAIL gap_resume k=%0d got=%b exp=%b", k, pdm_out, expv);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      enable = 1'b1;
      for (int k = 0; k < 400; k++) begin
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_addr = 2'($urandom_range(0, 3));
         wr_data = 8'($urandom_range(0, 255));
         commit  = ($urandom_range(0, 15) == 0);
         enable  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 63) == 0) mode = ~mode;
         cyc();
         n_chk++;
         if (pdm_out !== exp_pdm() || overload !== exp_ovl())
            $display("FAIL rnd k=%0d pdm=%b exp=%b ovl=%b exp=%b", k, pdm_out, exp_pdm(), overload, exp_ovl());
         else n_pass++;
      end
      wr_en = 1'b0; commit = 1'b0; enable = 1'b1;
   endtask

   task automatic test_reset_midrun();
      mode = 1'b1;
      write_level(0, 250);
      write_level(1, 5);
      write_level(2, int'($urandom_range(1, 255)));
      do_commit();
      repeat (30) cyc();
      #3 reset_n = 1'b0;
      #1;
      n_chk++;
      if (pdm_out !== '0 || overload !== '0)
         $display("FAIL midrun_async pdm=%b ovl=%b exp=000,000", pdm_out, overload);
      else n_pass++;
      model_reset();
      #2 reset_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         cyc();
         n_chk++;
         if (pdm_out !== '0 || overload !== '0 || pdm_out !== exp_pdm())
            $display("FAIL midrun_hold k=%0d pdm=%b ovl=%b exp=000,000", k, pdm_out, overload);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_first_order();
      test_double_buffer();
      test_second_order();
      test_mode_toggle();
      test_enable_gap();
      test_random();
      test_reset_midrun();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
